seq_frac_divider: RTL and testbench

Sequential signed fixed-point divider, the responder side of the dividend/divisor AXI-stream handshake that the attitude pipeline uses to form normalized quotients (e.g. L / |MN|) before the arcsin lookup. It accepts one 16-bit signed dividend/divisor pair per transaction and runs a radix-2 restoring division over 31 enabled cycles. It returns a 32-bit two's-complement Q17.15 quotient on a non-blocking master stream. It replaces the vendor divider core, with the same port names and clock-enable semantics.

---
 rtl/seq_frac_divider_pkg.sv | 17 +
 rtl/seq_frac_divider_if.sv | 43 ++++
 rtl/seq_frac_divider_step.sv | 21 ++
 rtl/seq_frac_divider.sv | 128 ++++++++++++
 tb/tb_seq_frac_divider.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/seq_frac_divider_pkg.sv
// Shared types and constants for the sequential fixed-point divider.
// Imported by the interface, the step cell and the top.
package div_pkg;

  localparam int DW_DEF   = 16;
  localparam int FRAC_DEF = 15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVIDE,
    S_FIXUP
  } state_e;

  localparam logic [31:0] SAT_POS = 32'h7FFFFFFF;
  localparam logic [31:0] SAT_NEG = 32'h80000001;

endpackage

// File: rtl/seq_frac_divider_if.sv
// Dividend/divisor request streams and quotient result stream.
// master = initiator side, slave = divider side.
interface seq_frac_divider_if
  import div_pkg::*;
#(
  parameter int DW = DW_DEF
);

  logic [DW-1:0]   s_axis_dividend_tdata;
  logic            s_axis_dividend_tvalid;
  logic            s_axis_dividend_tready;
  logic [DW-1:0]   s_axis_divisor_tdata;
  logic            s_axis_divisor_tvalid;
  logic            s_axis_divisor_tready;
  logic [2*DW-1:0] m_axis_dout_tdata;
  logic            m_axis_dout_tuser;
  logic            m_axis_dout_tvalid;

  modport master (
    output s_axis_dividend_tdata,
    output s_axis_dividend_tvalid,
    input  s_axis_dividend_tready,
    output s_axis_divisor_tdata,
    output s_axis_divisor_tvalid,
    input  s_axis_divisor_tready,
    input  m_axis_dout_tdata,
    input  m_axis_dout_tuser,
    input  m_axis_dout_tvalid
  );

  modport slave (
    input  s_axis_dividend_tdata,
    input  s_axis_dividend_tvalid,
    output s_axis_dividend_tready,
    input  s_axis_divisor_tdata,
    input  s_axis_divisor_tvalid,
    output s_axis_divisor_tready,
    output m_axis_dout_tdata,
    output m_axis_dout_tuser,
    output m_axis_dout_tvalid
  );

endinterface

// File: rtl/seq_frac_divider_step.sv
// One combinational radix-2 restoring division step.
// Remainder stays below the divisor, so DW bits hold it.
module div_step #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] rem_i,
  input  logic [DW-1:0] div_i,
  input  logic          bit_i,
  output logic [DW-1:0] rem_o,
  output logic          q_o
);

  logic [DW:0]   sh;
  logic [DW-1:0] diff;

  assign sh    = {rem_i, bit_i};
  assign diff  = sh[DW-1:0] - div_i;
  assign q_o   = (sh >= {1'b0, div_i});
  assign rem_o = q_o ? diff : sh[DW-1:0];

endmodule

// File: rtl/seq_frac_divider.sv
// Sequential signed Q17.15 divider: 31 restoring iterations
// plus a sign/saturation fixup cycle, gated by aclken.
module seq_frac_divider
  import div_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            aclken,
  input  logic [DW-1:0]   s_axis_dividend_tdata,
  input  logic            s_axis_dividend_tvalid,
  output logic            s_axis_dividend_tready,
  input  logic [DW-1:0]   s_axis_divisor_tdata,
  input  logic            s_axis_divisor_tvalid,
  output logic            s_axis_divisor_tready,
  output logic [2*DW-1:0] m_axis_dout_tdata,
  output logic            m_axis_dout_tuser,
  output logic            m_axis_dout_tvalid
);

  localparam int NB = DW + FRAC;
  localparam int RW = 2 * DW;
  localparam int CW = $clog2(NB);

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [NB-1:0]  dvd_q;
  logic [NB-1:0]  quo_q;
  logic [DW-1:0]  rem_q;
  logic [DW-1:0]  div_q;
  logic           sign_q;
  logic           aneg_q;
  logic           zero_q;
  logic [RW-1:0]  tdata_q;
  logic           tuser_q;
  logic           tvalid_q;

  logic [DW-1:0]  a_abs;
  logic [DW-1:0]  b_abs;
  logic [DW-1:0]  rem_d;
  logic           qbit_d;
  logic [RW-1:0]  mag;
  logic [RW-1:0]  res_d;
  logic           rdy;

  // -(-2^(DW-1)) wraps to 2^(DW-1), which is the right unsigned magnitude
  assign a_abs = s_axis_dividend_tdata[DW-1] ?
                 -s_axis_dividend_tdata : s_axis_dividend_tdata;
  assign b_abs = s_axis_divisor_tdata[DW-1] ?
                 -s_axis_divisor_tdata : s_axis_divisor_tdata;

  assign rdy = (state_q == S_IDLE) & aclken;
  assign s_axis_dividend_tready = rdy;
  assign s_axis_divisor_tready  = rdy;

  div_step #(
    .DW (DW)
  ) u_step (
    .rem_i (rem_q),
    .div_i (div_q),
    .bit_i (dvd_q[NB-1]),
    .rem_o (rem_d),
    .q_o   (qbit_d)
  );

  assign mag   = {{(RW-NB){1'b0}}, quo_q};
  assign res_d = zero_q ? (aneg_q ? SAT_NEG : SAT_POS)
                        : (sign_q ? -mag : mag);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      sign_q   <= 1'b0;
      aneg_q   <= 1'b0;
      zero_q   <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else if (aclken) begin
      tvalid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (s_axis_dividend_tvalid && s_axis_divisor_tvalid) begin
            dvd_q   <= {a_abs, {FRAC{1'b0}}};
            div_q   <= b_abs;
            rem_q   <= '0;
            quo_q   <= '0;
            sign_q  <= s_axis_dividend_tdata[DW-1] ^
                       s_axis_divisor_tdata[DW-1];
            aneg_q  <= s_axis_dividend_tdata[DW-1];
            zero_q  <= (s_axis_divisor_tdata == '0);
            cnt_q   <= CW'(NB - 1);
            state_q <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          rem_q <= rem_d;
          quo_q <= {quo_q[NB-2:0], qbit_d};
          dvd_q <= {dvd_q[NB-2:0], 1'b0};
          if (cnt_q == '0) begin
            state_q <= S_FIXUP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_FIXUP: begin
          tdata_q  <= res_d;
          tuser_q  <= zero_q;
          tvalid_q <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m_axis_dout_tdata  = tdata_q;
  assign m_axis_dout_tuser  = tuser_q;
  assign m_axis_dout_tvalid = tvalid_q;

endmodule

// File: tb/tb_seq_frac_divider.sv
// Directed and randomized checks of seq_frac_divider against
// an arithmetic quotient model.
module tb_seq_frac_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  always #5 clk = ~clk;

  seq_frac_divider_if #(.DW(16)) bus ();

  seq_frac_divider dut (
    .aclk                   (clk),
    .aresetn                (rst_n),
    .aclken                 (en),
    .s_axis_dividend_tdata  (bus.s_axis_dividend_tdata),
    .s_axis_dividend_tvalid (bus.s_axis_dividend_tvalid),
    .s_axis_dividend_tready (bus.s_axis_dividend_tready),
    .s_axis_divisor_tdata   (bus.s_axis_divisor_tdata),
    .s_axis_divisor_tvalid  (bus.s_axis_divisor_tvalid),
    .s_axis_divisor_tready  (bus.s_axis_divisor_tready),
    .m_axis_dout_tdata      (bus.m_axis_dout_tdata),
    .m_axis_dout_tuser      (bus.m_axis_dout_tuser),
    .m_axis_dout_tvalid     (bus.m_axis_dout_tvalid)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic signed [15:0] ra, rb;

  function automatic logic [31:0] model(input int a, input int b);
    longint q;
    longint ma;
    longint mb;
    if (b == 0) return (a >= 0) ? 32'h7FFFFFFF : 32'h80000001;
    ma = (a < 0) ? -longint'(a) : longint'(a);
    mb = (b < 0) ? -longint'(b) : longint'(b);
    q = (ma * 32768) / mb;
    if ((a < 0) != (b < 0)) q = -q;
    return q[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic va, input logic vb);
    bus.s_axis_dividend_tdata  = a;
    bus.s_axis_divisor_tdata   = b;
    bus.s_axis_dividend_tvalid = va;
    bus.s_axis_divisor_tvalid  = vb;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (bus.m_axis_dout_tvalid !== 1'b1 && k < 100);
  endtask

  task automatic run(input int a, input int b, input string tag);
    int k;
    logic [31:0] exp;
    exp = model(a, b);
    chk({tag, " rdy"}, 32'(bus.s_axis_dividend_tready), 32'd1);
    drive(a[15:0], b[15:0], 1'b1, 1'b1);
    step();
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    wait_valid(k);
    chk({tag, " lat"}, 32'(k), 32'd32);
    chk({tag, " data"}, bus.m_axis_dout_tdata, exp);
    chk({tag, " user"}, 32'(bus.m_axis_dout_tuser), 32'(b == 0));
    step();
    chk({tag, " pulse"}, 32'(bus.m_axis_dout_tvalid), 32'd0);
    chk({tag, " hold"}, bus.m_axis_dout_tdata, exp);
  endtask

  initial begin
    int k;
    int seen;
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    repeat (2) step();
    chk("rst data", bus.m_axis_dout_tdata, 32'h0);
    chk("rst user", 32'(bus.m_axis_dout_tuser), 32'd0);
    chk("rst valid", 32'(bus.m_axis_dout_tvalid), 32'd0);
    chk("rst rdy", 32'(bus.s_axis_dividend_tready), 32'd0);
    rst_n = 1'b1;
    en = 1'b1;
    #1;
    chk("en rdy", 32'(bus.s_axis_divisor_tready), 32'd1);
    step();

    run(3000, 6000, "half");
    chk("half exact", bus.m_axis_dout_tdata, 32'h00004000);
    run(-16384, 32767, "negq");
    chk("negq exact", bus.m_axis_dout_tdata, 32'hFFFFC000);
    run(-32768, 1, "maxmag");
    chk("maxmag exact", bus.m_axis_dout_tdata, 32'hC0000000);
    run(7, 0, "dz pos");
    run(-7, 0, "dz neg");

    // dividend valid alone must not be accepted
    drive(16'd1000, 16'd3000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("solo rdy", 32'(bus.s_axis_dividend_tready), 32'd1);
    end
    bus.s_axis_divisor_tvalid = 1'b1;
    step();
    drive(-16'sd5000, 16'sd7000, 1'b1, 1'b1);
    wait_valid(k);
    chk("b2b lat1", 32'(k), 32'd32);
    chk("b2b data1", bus.m_axis_dout_tdata, model(1000, 3000));
    chk("b2b rdy", 32'(bus.s_axis_divisor_tready), 32'd1);
    step();
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    wait_valid(k);
    chk("b2b lat2", 32'(k), 32'd32);
    chk("b2b data2", bus.m_axis_dout_tdata, model(-5000, 7000));
    step();

    // clock-enable stall in DIVIDE, then a stretched pulse
    drive(16'd100, 16'd400, 1'b1, 1'b1);
    step();
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    repeat (5) step();
    en = 1'b0;
    repeat (10) step();
    en = 1'b1;
    wait_valid(k);
    chk("en lat", 32'(k), 32'd27);
    chk("en data", bus.m_axis_dout_tdata, 32'h00002000);
    en = 1'b0;
    repeat (3) step();
    chk("stretch", 32'(bus.m_axis_dout_tvalid), 32'd1);
    en = 1'b1;
    step();
    chk("stretch end", 32'(bus.m_axis_dout_tvalid), 32'd0);

    // asynchronous reset mid-division
    drive(16'd1234, 16'd567, 1'b1, 1'b1);
    step();
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    repeat (12) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst data", bus.m_axis_dout_tdata, 32'h0);
    chk("arst user", 32'(bus.m_axis_dout_tuser), 32'd0);
    chk("arst valid", 32'(bus.m_axis_dout_tvalid), 32'd0);
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.m_axis_dout_tvalid === 1'b1) seen++;
    end
    chk("arst novalid", 32'(seen), 32'd0);
    run(100, 200, "post rst");
    chk("post rst exact", bus.m_axis_dout_tdata, 32'h00004000);

    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom);
      rb = (i % 5 == 4) ? 16'sd0 : 16'($urandom);
      if (i % 7 == 3) rb = 16'sd1;
      run(int'(ra), int'(rb), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
